// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit with pipeline stall.
// Multiply is shift-add over WIDTH cycles; divide is restoring over WIDTH cycles.
// Divide-by-zero and signed overflow bypass the iteration (done two cycles after start).
// Optional feature: define MULDIV_KILL_EN to add a 'kill' flush input.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
`ifdef MULDIV_KILL_EN
    input  logic             kill,
`endif
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      count;
    logic [2:0]         op;
    logic               neg_a, neg_b, special;
    // mul: {partial product hi, multiplier lo}; div: {remainder hi, dividend/quotient lo}
    logic [2*WIDTH-1:0] acc;
    // mul: multiplicand magnitude; div: divisor magnitude
    logic [WIDTH-1:0]   opnd;

    logic kill_i;
`ifdef MULDIV_KILL_EN
    assign kill_i = kill;
`else
    assign kill_i = 1'b0;
`endif

    // Operand decode at accept time
    logic             idle_like, accept, is_div_in, a_signed_in, b_signed_in;
    logic             sa_in, sb_in, div_zero_in, ovf_in, special_in;
    logic [WIDTH-1:0] a_mag, b_mag, special_val;

    assign idle_like   = (state == IDLE) || (state == DONE);
    assign accept      = start && !kill_i && idle_like;
    assign is_div_in   = funct3[2];
    // MULHU, DIVU, REMU treat rs1 as unsigned; MULHSU also treats rs2 as unsigned
    assign a_signed_in = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    assign b_signed_in = a_signed_in && (funct3 != 3'b010);
    assign sa_in       = a_signed_in && rs1[WIDTH-1];
    assign sb_in       = b_signed_in && rs2[WIDTH-1];
    assign a_mag       = sa_in ? (~rs1 + 1'b1) : rs1;
    assign b_mag       = sb_in ? (~rs2 + 1'b1) : rs2;
    assign div_zero_in = is_div_in && (rs2 == '0);
    assign ovf_in      = is_div_in && !funct3[0] && (rs1 == MIN_VAL) && (rs2 == '1);
    assign special_in  = div_zero_in || ovf_in;

    // Bypass result: divide-by-zero gives all ones / dividend, overflow gives MIN / 0
    always_comb begin
        special_val = '0;
        if (div_zero_in) special_val = funct3[1] ? rs1 : '1;
        else if (ovf_in) special_val = funct3[1] ? '0 : MIN_VAL;
    end

    // One iteration step for each algorithm
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_step, div_step;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_step  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (!div_diff[WIDTH]) div_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else                  div_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    // Sign correction and half/quotient/remainder selection in FIN
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, fin_val;

    always_comb begin
        prod    = (neg_a ^ neg_b) ? (~acc + 1'b1) : acc;
        quo     = (neg_a ^ neg_b) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem     = neg_a ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
        fin_val = '0;
        if (special)              fin_val = acc[WIDTH-1:0];
        else if (!op[2])          fin_val = (op[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        else if (op[1])           fin_val = rem;
        else                      fin_val = quo;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; kill flushes an in-flight op back to IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (accept) state_nx = special_in ? FIN : CALC;
                else        state_nx = IDLE;
            end
            CALC:    if (count == LAST) state_nx = FIN;
            FIN:     state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        if (kill_i && (state == CALC || state == FIN)) state_nx = IDLE;
    end

    // Operand latch, iteration datapath and result register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            op      <= '0;
            neg_a   <= 1'b0;
            neg_b   <= 1'b0;
            special <= 1'b0;
            acc     <= '0;
            opnd    <= '0;
            result  <= '0;
        end else begin
            if (accept) begin
                op      <= funct3;
                neg_a   <= sa_in;
                neg_b   <= sb_in;
                special <= special_in;
                count   <= '0;
                if (special_in) begin
                    acc  <= {{WIDTH{1'b0}}, special_val};
                    opnd <= '0;
                end else if (is_div_in) begin
                    acc  <= {{WIDTH{1'b0}}, a_mag};
                    opnd <= b_mag;
                end else begin
                    acc  <= {{WIDTH{1'b0}}, b_mag};
                    opnd <= a_mag;
                end
            end else if (state == CALC) begin
                if (count != LAST) count <= count + 1'b1;
                acc <= op[2] ? div_step : mul_step;
            end
            if (state == FIN && !kill_i) result <= fin_val;
        end
    end

    assign busy  = (state == CALC) || (state == FIN);
    assign done  = (state == DONE);
    assign stall = busy || (start && idle_like);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected results,
// a negedge monitor pops and compares result and latency whenever done is high.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   funct3 = '0;
    logic [W-1:0] rs1 = '0, rs2 = '0;
`ifdef MULDIV_KILL_EN
    logic         kill = 1'b0;
`endif
    logic         busy, stall, done;
    logic [W-1:0] result;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
`ifdef MULDIV_KILL_EN
        .kill(kill),
`endif
        .rs1(rs1), .rs2(rs2), .busy(busy), .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] res; int t0; int lat; } exp_t;
    exp_t sb[$];
    int total = 0, passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: RV32M semantics via wide integer arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sbv, p;
        longint unsigned ua, ub, pu;
        int              ia, ib;
        sa = longint'($signed(a)); sbv = longint'($signed(b));
        ua = {32'b0, a}; ub = {32'b0, b};
        ia = $signed(a); ib = $signed(b);
        case (f)
            3'd0: begin p = sa * sbv; return p[31:0]; end
            3'd1: begin p = sa * sbv; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin pu = ua * ub; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
        return W + 2;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation
    exp_t e_mon;
    always @(negedge clk) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_done actual=1 expected=0 result=%h", result);
            end else begin
                e_mon = sb.pop_front();
                chk("result", result, e_mon.res);
                chk("latency", 32'(cyc - e_mon.t0), 32'(e_mon.lat));
            end
        end
    end

    // Issue one op at a negedge; returns at the negedge of its DONE cycle.
    // poke>0 pulses a stray start during cycle 'poke' of the op.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int poke);
        exp_t e;
        bit   bok;
        e.res = model(f, a, b); e.t0 = cyc; e.lat = model_lat(f, a, b);
        sb.push_back(e);
        funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bok = 1'b1;
        for (int k = 1; k <= e.lat; k++) begin
            if (busy !== (k < e.lat)) bok = 1'b0;
            if (k == poke)     begin start = 1'b1; funct3 = 3'd5; rs1 = $urandom; rs2 = 32'd3; end
            if (k == poke + 1) start = 1'b0;
            if (k < e.lat) @(negedge clk);
        end
        chk("busy_profile", {31'b0, bok}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            $display("FAIL done_timeout actual=%0d expected=0 outstanding", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    logic [2:0]  rf;
    logic [31:0] ra, rb;

    initial begin
        // Reset state
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_stall_idle", {31'b0, stall}, 32'd0);
        start = 1'b1; #1;
        chk("rst_stall_start", {31'b0, stall}, 32'd1);
        start = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 0);             drain();
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);     drain();
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);     drain();
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 0);             drain();
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 0);             drain();
        issue(3'd5, 32'd5, 32'd0, 0);                     drain();
        issue(3'd6, 32'd5, 32'd0, 0);                     drain();
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);     drain();
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);     drain();
        issue(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);     drain();
        issue(3'd0, 32'd0, 32'h1234_5678, 0);             drain();
        // Stray start mid-operation is ignored
        issue(3'd0, 32'd123, 32'd456, 10);                drain();
        repeat (40) @(negedge clk);
        // Back-to-back issue from DONE
        issue(3'd7, 32'd100, 32'd7, 0);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        issue(3'd5, 32'd9, 32'd0, 0);                     drain();

        // Reset mid-operation aborts with no done
        funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b0; #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_stall", {31'b0, stall}, 32'd0);
        start = 1'b1; #1;
        chk("abort_stall_start", {31'b0, stall}, 32'd1);
        start = 1'b0;
        @(negedge clk); reset = 1'b1;
        repeat (40) @(negedge clk);

`ifdef MULDIV_KILL_EN
        // Kill mid-operation: back to IDLE, no done, result kept
        issue(3'd0, 32'd6, 32'd7, 0); drain();
        funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (14) @(negedge clk);
        kill = 1'b1; @(negedge clk); kill = 1'b0;
        chk("kill_busy", {31'b0, busy}, 32'd0);
        chk("kill_result", result, 32'd42);
        repeat (40) @(negedge clk);
`endif

        // Randomized ops with biased corner operands
        for (int i = 0; i < 60; i++) begin
            rf = 3'($urandom_range(0, 7)); ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: ra = $urandom_range(0, 100);
                3: rb = $urandom_range(1, 20);
                default: ;
            endcase
            issue(rf, ra, rb, 0);
            drain();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
